// File: rtl/world_time_conv_if.sv
// Signal bundle between the world-clock zone converter and its surroundings:
// local time and zone select in, converted time and zone-display flag out.
`timescale 1ns/1ps
interface world_time_conv_if;
   logic       tick_1hz;
   logic [3:0] state;
   logic [2:0] inworld;
   logic [4:0] loc_hour;
   logic [5:0] loc_min;
   logic [5:0] loc_sec;
   logic [4:0] w_hour;
   logic [5:0] w_min;
   logic [5:0] w_sec;
   logic [1:0] day_adj;
   logic       zone_show;

   modport master (
      output tick_1hz, state, inworld, loc_hour, loc_min, loc_sec,
      input  w_hour, w_min, w_sec, day_adj, zone_show
   );

   modport slave (
      input  tick_1hz, state, inworld, loc_hour, loc_min, loc_sec,
      output w_hour, w_min, w_sec, day_adj, zone_show
   );
endinterface

// File: rtl/world_time_conv.sv
// Converts local time to the selected zone's time (2-stage pipeline, 24 h wrap,
// day-adjust flag) and raises zone_show for a few 1 Hz ticks after a zone change.
`timescale 1ns/1ps
module world_time_conv #(
   parameter logic [3:0] WORLD_STATE = 4'd8,
   parameter int         SHOW_TICKS  = 3,
   parameter int         OFF0        = 0,
   parameter int         OFF1        = -14,
   parameter int         OFF2        = -9,
   parameter int         OFF3        = -8,
   parameter int         OFF4        = 1
) (
   input logic              clk,
   input logic              reset,
   world_time_conv_if.slave bus
);

   typedef enum logic {IDLE, SHOW} fsm_t;

   logic [2:0]        zone_san;
   logic signed [5:0] off_sel;
   logic signed [5:0] off_s1_reg;
   logic [4:0]        hour_s1_reg;
   logic [5:0]        min_s1_reg;
   logic [5:0]        sec_s1_reg;
   logic signed [6:0] sum;
   logic [4:0]        hour_next;
   logic [1:0]        day_next;
   logic [4:0]        w_hour_reg;
   logic [5:0]        w_min_reg;
   logic [5:0]        w_sec_reg;
   logic [1:0]        day_adj_reg;
   logic [2:0]        last_zone_reg;
   logic              chg;
   fsm_t              fsm_reg, fsm_next;
   logic [3:0]        cnt_reg, cnt_next;

   // Unused zone codes fold onto the local zone so 7->0 is not a change.
   assign zone_san = (bus.inworld > 3'd4) ? 3'd0 : bus.inworld;

   always_comb begin
      off_sel = 6'(OFF0);
      case (zone_san)
         3'd1:    off_sel = 6'(OFF1);
         3'd2:    off_sel = 6'(OFF2);
         3'd3:    off_sel = 6'(OFF3);
         3'd4:    off_sel = 6'(OFF4);
         default: off_sel = 6'(OFF0);
      endcase
   end

   // Offsets span -23..+23, so a single +/-24 correction always lands in 0..23.
   always_comb begin
      sum       = $signed({2'b00, hour_s1_reg}) + $signed({off_s1_reg[5], off_s1_reg});
      hour_next = 5'(sum);
      day_next  = 2'b00;
      if (sum < 7'sd0) begin
         hour_next = 5'(sum + 7'sd24);
         day_next  = 2'b11;
      end else if (sum >= 7'sd24) begin
         hour_next = 5'(sum - 7'sd24);
         day_next  = 2'b01;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         off_s1_reg  <= '0;
         hour_s1_reg <= '0;
         min_s1_reg  <= '0;
         sec_s1_reg  <= '0;
         w_hour_reg  <= '0;
         w_min_reg   <= '0;
         w_sec_reg   <= '0;
         day_adj_reg <= 2'b00;
      end else begin
         off_s1_reg  <= off_sel;
         hour_s1_reg <= bus.loc_hour;
         min_s1_reg  <= bus.loc_min;
         sec_s1_reg  <= bus.loc_sec;
         w_hour_reg  <= hour_next;
         w_min_reg   <= min_s1_reg;
         w_sec_reg   <= sec_s1_reg;
         day_adj_reg <= day_next;
      end
   end

   assign chg = (zone_san != last_zone_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_zone_reg <= 3'd0;
         fsm_reg       <= IDLE;
         cnt_reg       <= 4'd0;
      end else begin
         last_zone_reg <= zone_san;
         fsm_reg       <= fsm_next;
         cnt_reg       <= cnt_next;
      end
   end

   // A zone change always restarts the display window, even on a tick cycle.
   always_comb begin
      fsm_next = fsm_reg;
      cnt_next = cnt_reg;
      case (fsm_reg)
         IDLE: begin
            if (chg) begin
               fsm_next = SHOW;
               cnt_next = 4'd0;
            end
         end
         SHOW: begin
            if (chg) begin
               cnt_next = 4'd0;
            end else if (bus.tick_1hz) begin
               if (cnt_reg + 4'd1 == 4'(SHOW_TICKS)) begin
                  fsm_next = IDLE;
                  cnt_next = 4'd0;
               end else begin
                  cnt_next = cnt_reg + 4'd1;
               end
            end
         end
         default: begin
            fsm_next = IDLE;
            cnt_next = 4'd0;
         end
      endcase
   end

   assign bus.w_hour    = w_hour_reg;
   assign bus.w_min     = w_min_reg;
   assign bus.w_sec     = w_sec_reg;
   assign bus.day_adj   = day_adj_reg;
   assign bus.zone_show = (fsm_reg == SHOW) && (bus.state == WORLD_STATE);

endmodule

// File: tb/tb_world_time_conv.sv
// Directed bench for world_time_conv: conversion pipeline, async reset and
// the zone_show display window.
`timescale 1ns/1ps
module tb_world_time_conv;

   typedef struct {
      logic [2:0] z;
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic [4:0] eh;
      logic [1:0] ed;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;
   vec_t vecs [8];

   always #5 clk = ~clk;

   world_time_conv_if bus ();

   world_time_conv dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
      $display("[TB] %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_out(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s, input logic [1:0] d);
      check({tag, ".hour"}, 32'(bus.w_hour), 32'(h));
      check({tag, ".min"},  32'(bus.w_min),  32'(m));
      check({tag, ".sec"},  32'(bus.w_sec),  32'(s));
      check({tag, ".day"},  32'(bus.day_adj), 32'(d));
   endtask

   task automatic tick();
      bus.tick_1hz = 1'b1;
      step();
      bus.tick_1hz = 1'b0;
   endtask

   initial begin
      vecs[0] = '{3'd4, 5'd23, 6'd59, 6'd59, 5'd0,  2'b01};
      vecs[1] = '{3'd0, 5'd12, 6'd0,  6'd0,  5'd12, 2'b00};
      vecs[2] = '{3'd2, 5'd3,  6'd7,  6'd45, 5'd18, 2'b11};
      vecs[3] = '{3'd3, 5'd8,  6'd15, 6'd20, 5'd0,  2'b00};
      vecs[4] = '{3'd1, 5'd20, 6'd1,  6'd2,  5'd6,  2'b00};
      vecs[5] = '{3'd4, 5'd22, 6'd33, 6'd44, 5'd23, 2'b00};
      vecs[6] = '{3'd6, 5'd10, 6'd11, 6'd12, 5'd10, 2'b00};
      vecs[7] = '{3'd1, 5'd13, 6'd40, 6'd50, 5'd23, 2'b11};

      // Reset held with nonzero inputs.
      bus.tick_1hz = 1'b0;
      bus.state    = 4'd8;
      bus.inworld  = 3'd1;
      bus.loc_hour = 5'd5;
      bus.loc_min  = 6'd30;
      bus.loc_sec  = 6'd10;
      step();
      step();
      check_out("reset", 5'd0, 6'd0, 6'd0, 2'b00);
      check("reset.zone_show", 32'(bus.zone_show), 32'd0);

      // Zone 1, 05:30:10 -> 15:30:10 previous day, two clocks after apply.
      reset     = 1'b1;
      bus.state = 4'd0;
      step();
      check("lat1.hour", 32'(bus.w_hour), 32'd0);
      step();
      check_out("z1", 5'd15, 6'd30, 6'd10, 2'b11);

      // Back-to-back vectors, one per clock.
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            bus.inworld  = vecs[i].z;
            bus.loc_hour = vecs[i].h;
            bus.loc_min  = vecs[i].m;
            bus.loc_sec  = vecs[i].s;
         end
         step();
         if (i >= 1)
            check_out($sformatf("stream%0d", i - 1), vecs[i-1].eh, vecs[i-1].m,
                      vecs[i-1].s, vecs[i-1].ed);
      end

      // Asynchronous reset mid-run clears outputs without a clock edge.
      #2;
      reset = 1'b0;
      #1;
      check_out("async_rst", 5'd0, 6'd0, 6'd0, 2'b00);

      bus.inworld = 3'd0;
      bus.state   = 4'd8;
      step();
      reset = 1'b1;
      step();
      check("idle.zone_show", 32'(bus.zone_show), 32'd0);

      // Zone 0 -> 2 opens a three-tick display window.
      bus.inworld = 3'd2;
      step();
      check("z2.show", 32'(bus.zone_show), 32'd1);
      tick();
      check("z2.tick1", 32'(bus.zone_show), 32'd1);
      tick();
      check("z2.tick2", 32'(bus.zone_show), 32'd1);
      tick();
      check("z2.tick3", 32'(bus.zone_show), 32'd0);

      // Restart on change; change coinciding with a tick wins.
      bus.inworld = 3'd4;
      step();
      bus.inworld = 3'd2;
      step();
      check("rs.show", 32'(bus.zone_show), 32'd1);
      tick();
      tick();
      check("rs.tick2", 32'(bus.zone_show), 32'd1);
      bus.inworld = 3'd3;
      tick();
      check("rs.chg_tick", 32'(bus.zone_show), 32'd1);
      tick();
      check("rs.after1", 32'(bus.zone_show), 32'd1);
      tick();
      check("rs.after2", 32'(bus.zone_show), 32'd1);
      tick();
      check("rs.after3", 32'(bus.zone_show), 32'd0);

      // Zone 0 then 7 -> no new window.
      bus.inworld = 3'd0;
      step();
      check("z0.show", 32'(bus.zone_show), 32'd1);
      tick();
      tick();
      tick();
      check("z0.done", 32'(bus.zone_show), 32'd0);
      bus.inworld = 3'd7;
      step();
      check("z7.show", 32'(bus.zone_show), 32'd0);
      step();
      check("z7.show2", 32'(bus.zone_show), 32'd0);

      // Outside world mode the flag is masked but the window keeps counting.
      bus.state   = 4'd4;
      bus.inworld = 3'd1;
      step();
      check("mask.show", 32'(bus.zone_show), 32'd0);
      bus.state = 4'd8;
      #1;
      check("unmask.show", 32'(bus.zone_show), 32'd1);
      bus.state = 4'd4;
      tick();
      tick();
      bus.state = 4'd8;
      #1;
      check("mask.counted", 32'(bus.zone_show), 32'd1);
      tick();
      check("mask.expire", 32'(bus.zone_show), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
